// File: rtl/clk_rst_smpl_pkg.sv
// clk_rst_smpl_pkg: shared constants, decimation clamp/rate helpers and retune state type
`timescale 1ns/1ps
package clk_rst_smpl_pkg;
   localparam int SMPL_PER_WRD_DEF = 4;
   localparam int RETUNE_CYC_DEF   = 16;
   localparam int SMPL_CNT_W       = $clog2(SMPL_PER_WRD_DEF);
   localparam int RETUNE_W         = $clog2(RETUNE_CYC_DEF);

   typedef enum logic {RUN, HOLD} retune_state_t;

   function automatic int eff_dec(input int dec, input int max_dec);
      return (dec > max_dec) ? max_dec : dec;
   endfunction

   // a word's worth of samples arrives within one clk period, so full never drops
   function automatic logic is_fast(input int dec, input int sys_div_log2, input int smpl_per_wrd);
      return dec + $clog2(smpl_per_wrd) <= sys_div_log2;
   endfunction
endpackage

// File: rtl/rst_synch_neg.sv
// rst_synch_neg: two-flop reset synchroniser on negedge clock with asynchronous clear
`timescale 1ns/1ps
module rst_synch_neg (
   input  logic clk_i,
   input  logic arst_ni,
   input  logic d_i,
   output logic q_o
);
   logic [1:0] sync_q;

   always_ff @(negedge clk_i or negedge arst_ni)
      if (!arst_ni) sync_q <= '0;
      else          sync_q <= {sync_q[0], d_i};

   assign q_o = sync_q[1];
endmodule

// File: rtl/clk_rst_smpl_gen.sv
// clk_rst_smpl_gen: system clock divide, reset synchronisation, decimated sample clock,
// glitch-free retune and RAM word write strobe for the capture front end
`timescale 1ns/1ps
module clk_rst_smpl_gen
   import clk_rst_smpl_pkg::*;
#(
   parameter int SYS_DIV_LOG2 = 2,
   parameter int DEC_W        = 4,
   parameter int MAX_DEC      = 10,
   parameter int SMPL_PER_WRD = SMPL_PER_WRD_DEF,
   parameter int RETUNE_CYC   = RETUNE_CYC_DEF
)(
   input  logic             clk400MHz,
   input  logic             RST_n,
   input  logic             locked,
   input  logic [DEC_W-1:0] decimator,
   output logic             clk,
   output logic             smpl_clk,
   output logic             rst_n,
   output logic             wrt_smpl,
   output logic             dec_busy
);
   localparam int CW = $clog2(SMPL_PER_WRD);
   localparam int RW = $clog2(RETUNE_CYC);

   logic [1:0]              lock_q;
   logic                    locked_s, arst_n, lock_sys_q;
   logic [SYS_DIV_LOG2-1:0] sys_q;

   always_ff @(posedge clk400MHz or negedge RST_n)
      if (!RST_n) lock_q <= '0;
      else        lock_q <= {lock_q[0], locked};

   assign locked_s = lock_q[1];
   assign arst_n   = RST_n & locked_s;

   always_ff @(posedge clk400MHz or negedge arst_n)
      if (!arst_n) sys_q <= '0;
      else         sys_q <= sys_q + 1'b1;

   assign clk = sys_q[SYS_DIV_LOG2-1];

   always_ff @(negedge clk or negedge arst_n)
      if (!arst_n) lock_sys_q <= 1'b0;
      else         lock_sys_q <= locked_s;

   rst_synch_neg u_rst_synch (
      .clk_i   (clk),
      .arst_ni (arst_n),
      .d_i     (lock_sys_q),
      .q_o     (rst_n)
   );

   retune_state_t    state_q, state_d;
   logic [DEC_W-1:0] dec_req, dec_q, dec_d, tgt_q, tgt_d;
   logic [RW-1:0]    rcnt_q, rcnt_d;

   assign dec_req = DEC_W'(eff_dec(int'(decimator), MAX_DEC));

   always_ff @(negedge clk400MHz or negedge arst_n)
      if (!arst_n) begin
         state_q <= RUN;
         dec_q   <= DEC_W'(MAX_DEC);
         tgt_q   <= DEC_W'(MAX_DEC);
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         dec_q   <= dec_d;
         tgt_q   <= tgt_d;
         rcnt_q  <= rcnt_d;
      end

   // a new request while holding restarts the hold with the latest target
   always_comb begin
      state_d = state_q;
      dec_d   = dec_q;
      tgt_d   = tgt_q;
      rcnt_d  = rcnt_q;
      if (state_q == RUN) begin
         if (dec_req != dec_q) begin
            state_d = HOLD;
            tgt_d   = dec_req;
            rcnt_d  = RW'(RETUNE_CYC - 1);
         end
      end else if (dec_req != tgt_q) begin
         tgt_d  = dec_req;
         rcnt_d = RW'(RETUNE_CYC - 1);
      end else if (rcnt_q == '0) begin
         state_d = RUN;
         dec_d   = tgt_q;
      end else begin
         rcnt_d = rcnt_q - 1'b1;
      end
   end

   assign dec_busy = (state_q == HOLD);

   logic [MAX_DEC-1:0] dcnt_q, sel;
   logic               div_q, fast;

   always_ff @(negedge clk400MHz or negedge arst_n)
      if (!arst_n) begin
         dcnt_q <= '0;
         div_q  <= 1'b0;
      end else begin
         dcnt_q <= (!lock_sys_q || dec_busy) ? '0 : dcnt_q + 1'b1;
         div_q  <= !dec_busy && |(dcnt_q & sel);
      end

   assign sel      = (dec_q == '0) ? '0 : MAX_DEC'(1) << (dec_q - 1'b1);
   assign smpl_clk = dec_busy ? 1'b0 : ((dec_q == '0) ? clk400MHz : div_q);
   assign fast     = is_fast(int'(dec_q), SYS_DIV_LOG2, SMPL_PER_WRD);

   logic          sclr_n, sfull_q, full_d_q, wrt_q;
   logic [CW-1:0] scnt_q;

   assign sclr_n = lock_sys_q & ~dec_busy;

   // full counter restarts only once the clk side has seen it full
   always_ff @(negedge smpl_clk or negedge sclr_n)
      if (!sclr_n) scnt_q <= '0;
      else         scnt_q <= (&scnt_q) ? (sfull_q ? '0 : scnt_q) : scnt_q + 1'b1;

   always_ff @(posedge clk or negedge sclr_n)
      if (!sclr_n) sfull_q <= 1'b0;
      else         sfull_q <= &scnt_q;

   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         full_d_q <= 1'b0;
         wrt_q    <= 1'b0;
      end else begin
         full_d_q <= sfull_q;
         wrt_q    <= rst_n & sfull_q & (~full_d_q | fast);
      end

   assign wrt_smpl = wrt_q & ~dec_busy;
endmodule

// File: tb/tb_clk_rst_smpl_gen.sv
// tb_clk_rst_smpl_gen: directed checks of clock start, reset release, decimation,
// retune hold, write strobe spacing, lock loss and push-button reset
`timescale 1ns/1ps
module tb_clk_rst_smpl_gen;
   logic       clk400MHz = 1'b0;
   logic       RST_n     = 1'b1;
   logic       locked    = 1'b0;
   logic [3:0] decimator = 4'd0;
   logic       clk, smpl_clk, rst_n, wrt_smpl, dec_busy;
   int         n_chk = 0, n_err = 0;

   clk_rst_smpl_gen dut (
      .clk400MHz (clk400MHz),
      .RST_n     (RST_n),
      .locked    (locked),
      .decimator (decimator),
      .clk       (clk),
      .smpl_clk  (smpl_clk),
      .rst_n     (rst_n),
      .wrt_smpl  (wrt_smpl),
      .dec_busy  (dec_busy)
   );

   always #1.25 clk400MHz = ~clk400MHz;

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_dec(input logic [3:0] v);
      @(posedge clk400MHz);
      #0.3 decimator = v;
   endtask

   task automatic clk_rise(output realtime t);
      logic prev;
      t = -1;
      @(posedge clk400MHz);
      #0.1 prev = clk;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk400MHz);
         #0.1;
         if (!prev && clk) begin
            t = $realtime;
            return;
         end
         prev = clk;
      end
   endtask

   task automatic smpl_fall(output realtime t);
      logic prev;
      t = -1;
      @(posedge clk400MHz);
      #0.3 prev = smpl_clk;
      for (int i = 0; i < 5000; i++) begin
         @(posedge clk400MHz);
         #0.3;
         if (prev && !smpl_clk) begin
            t = $realtime;
            return;
         end
         prev = smpl_clk;
      end
   endtask

   task automatic smpl_per(output longint ps);
      realtime a, b;
      smpl_fall(a);
      smpl_fall(b);
      ps = (a < 0 || b < 0) ? -1 : longint'((b - a) * 1000.0);
   endtask

   task automatic wrt_gap(output int w, output int g);
      int n;
      n = 0;
      w = 0;
      g = -1;
      @(negedge clk);
      while (wrt_smpl && n < 500) begin n++; @(negedge clk); end
      while (!wrt_smpl && n < 500) begin n++; @(negedge clk); end
      if (!wrt_smpl) return;
      g = 0;
      while (wrt_smpl && g < 500) begin w++; g++; @(negedge clk); end
      while (!wrt_smpl && g < 500) begin g++; @(negedge clk); end
      if (!wrt_smpl) g = -1;
   endtask

   task automatic wrt_high(input int n, output int h);
      h = 0;
      repeat (n) begin
         @(negedge clk);
         h += int'(wrt_smpl);
      end
   endtask

   task automatic check_all_low(input string tag);
      check({tag, "_clk"}, clk, 0);
      check({tag, "_rst_n"}, rst_n, 0);
      check({tag, "_wrt"}, wrt_smpl, 0);
      check({tag, "_busy"}, dec_busy, 0);
      check({tag, "_smpl"}, smpl_clk, 0);
   endtask

   initial begin
      #200us;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      int      n, w, g, h, nb, lo, wr, mism, clkhi;
      longint  ps;
      realtime a, b;
      #1 RST_n = 1'b0;
      #5 check_all_low("reset");
      RST_n = 1'b1;
      #20 check("clk_prelock", clk, 0);
      @(negedge clk400MHz);
      locked = 1'b1;
      n = 0;
      do begin @(posedge clk400MHz); #0.1; n++; end while (!clk && n < 20);
      check("clk_start_cycles", n, 4);
      n = 0;
      do begin @(negedge clk); #0.1; n++; end while (!rst_n && n < 20);
      check("rst_n_release_negedges", n, 3);
      clk_rise(a);
      clk_rise(b);
      check("clk_period_ps", (a < 0 || b < 0) ? -1 : longint'((b - a) * 1000.0), 10000);

      repeat (30) @(negedge clk);
      mism = 0;
      repeat (16) begin
         @(posedge clk400MHz); #0.3 mism += int'(smpl_clk !== 1'b1);
         @(negedge clk400MHz); #0.3 mism += int'(smpl_clk !== 1'b0);
      end
      check("dec0_passthru_mism", mism, 0);
      wrt_high(20, h);
      check("dec0_wrt_high", h, 20);

      set_dec(4'd3);
      repeat (30) @(negedge clk);
      smpl_per(ps);
      check("dec3_period_ps", ps, 20000);
      wrt_gap(w, g);
      check("dec3_wrt_width", w, 1);
      check("dec3_wrt_gap", g, 8);

      set_dec(4'd1);
      repeat (30) @(negedge clk);
      smpl_per(ps);
      check("dec1_period_ps", ps, 5000);
      wrt_gap(w, g);
      check("dec1_wrt_width", w, 1);
      check("dec1_wrt_gap", g, 2);

      set_dec(4'd3);
      repeat (30) @(negedge clk);
      set_dec(4'd5);
      nb = 0; lo = 0; wr = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk400MHz);
         #0.3;
         if (dec_busy) begin
            nb++;
            lo += int'(smpl_clk);
            wr += int'(wrt_smpl);
         end else if (nb > 0) break;
      end
      check("retune_busy_cycles", nb, 16);
      check("retune_smpl_high", lo, 0);
      check("retune_wrt_high", wr, 0);
      smpl_per(ps);
      check("dec5_period_ps", ps, 80000);
      wrt_gap(w, g);
      check("dec5_wrt_width", w, 1);
      check("dec5_wrt_gap", g, 32);

      set_dec(4'd12);
      smpl_per(ps);
      check("dec12_clamp_period_ps", ps, 2560000);

      set_dec(4'd0);
      repeat (30) @(negedge clk);
      wrt_high(10, h);
      check("dec0_wrt_high_again", h, 10);

      @(posedge clk400MHz);
      #0.3 locked = 1'b0;
      @(posedge clk400MHz);
      @(posedge clk400MHz);
      #0.3;
      check("lockloss_rst_n", rst_n, 0);
      check("lockloss_wrt", wrt_smpl, 0);
      clkhi = 0;
      repeat (12) begin @(posedge clk400MHz); #0.3 clkhi += int'(clk); end
      check("lockloss_clk_high", clkhi, 0);

      locked = 1'b1;
      for (int i = 0; i < 100 && !rst_n; i++) @(posedge clk400MHz);
      check("relock_rst_n", rst_n, 1);
      repeat (20) @(negedge clk);
      wrt_high(10, h);
      check("relock_wrt_high", h, 10);
      @(posedge clk400MHz);
      #0.7 RST_n = 1'b0;
      #0.1 check_all_low("pushbutton");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
